// File: rtl/round_robin_arbiter_n_with_lock.sv
// round_robin_arbiter_n_with_lock: circular-priority arbiter whose grantee may lock the grant for up to MAX_HOLD cycles
module round_robin_arbiter_n_with_lock #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         requests,
    input  logic [N-1:0]         lock,
    output logic [N-1:0]         grants,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 locked
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [IW-1:0] ptr_q, ptr_d, own_q, own_d, idx, arb_id;
    logic          own_v_q, own_v_d, arb_v, hold, take;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  arb_g;
    // first requester found searching circularly from the slot after the last grant
    always_comb begin
        arb_v  = 1'b0;
        arb_id = '0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (!arb_v && requests[idx]) begin
                arb_v  = 1'b1;
                arb_id = idx;
            end
        end
        arb_g = arb_v ? N'(1) << arb_id : '0;
    end
    // owner keeps the grant while still requesting; reset forces every output low
    always_comb begin
        hold        = own_v_q && requests[own_q];
        grants      = rst ? '0 : hold ? N'(1) << own_q : arb_g;
        grant_id    = rst ? '0 : hold ? own_q : arb_id;
        grant_valid = |grants;
        locked      = own_v_q && !rst;
    end
    // next-state: pointer follows every grant, ownership taken on lock and capped at MAX_HOLD
    always_comb begin
        ptr_d   = grant_valid ? grant_id : ptr_q;
        take    = !hold && arb_v && lock[arb_id] && (MAX_HOLD > 1);
        own_v_d = hold ? lock[own_q] && (int'(cnt_q) + 1 < MAX_HOLD) : take;
        own_d   = hold ? own_q : take ? arb_id : own_q;
        cnt_d   = hold ? (own_v_d ? cnt_q + CW'(1) : '0) : take ? CW'(1) : '0;
    end
    // state registers; reset leaves requester 0 at top priority
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= IW'(N - 1);
            own_q   <= '0;
            own_v_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            own_v_q <= own_v_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_round_robin_arbiter_n_with_lock.sv
// tb_round_robin_arbiter_n_with_lock: directed checks of rotation, locking, hold cap, idle and reset behaviour
module tb_round_robin_arbiter_n_with_lock;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] r4 = '0, l4 = '0, g4;
    logic [1:0] r2 = '0, l2 = '0, g2;
    logic [2:0] r3 = '0, l3 = '0, g3;
    logic [1:0] id4, id3;
    logic       id2, v4, v2, v3, lk4, lk2, lk3;
    int checks = 0;
    int errors = 0;

    round_robin_arbiter_n_with_lock #(.N(4), .MAX_HOLD(4)) d4 (
        .clk(clk), .rst(rst), .requests(r4), .lock(l4),
        .grants(g4), .grant_valid(v4), .grant_id(id4), .locked(lk4));
    round_robin_arbiter_n_with_lock #(.N(2), .MAX_HOLD(1)) d2 (
        .clk(clk), .rst(rst), .requests(r2), .lock(l2),
        .grants(g2), .grant_valid(v2), .grant_id(id2), .locked(lk2));
    round_robin_arbiter_n_with_lock #(.N(3), .MAX_HOLD(4)) d3 (
        .clk(clk), .rst(rst), .requests(r3), .lock(l3),
        .grants(g3), .grant_valid(v3), .grant_id(id3), .locked(lk3));

    always #5 clk = ~clk;

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        r4 = '0; l4 = '0; r2 = '0; l2 = '0; r3 = '0; l3 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        r4 = 4'hF; l4 = 4'hF; r2 = 2'b11; r3 = 3'b111;
        #4;
        checks++;
        if ({g4, v4, id4, lk4} !== 8'h00) begin
            errors++;
            $display("FAIL reset_n4 got g=%b v=%b id=%0d lk=%b want all 0", g4, v4, id4, lk4);
        end
        checks++;
        if ({g2, v2, g3, v3, lk2, lk3} !== 9'h000) begin
            errors++;
            $display("FAIL reset_n2n3 got g2=%b v2=%b g3=%b v3=%b want 0", g2, v2, g3, v3);
        end
        @(posedge clk); #1;
        rst = 1'b0; l4 = '0;
        #4;
        checks++;
        if (g4 !== 4'b0001 || id4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_first got g=%b id=%0d want 0001 id 0", g4, id4);
        end
    endtask

    task automatic test_rotate;
        logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ei [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            r4 = 4'hF; l4 = '0;
            #4;
            checks++;
            if (g4 !== eg[c] || id4 !== ei[c] || v4 !== 1'b1) begin
                errors++;
                $display("FAIL rotate c%0d got g=%b id=%0d v=%b want g=%b id=%0d", c, g4, id4, v4, eg[c], ei[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_n2_no_hold;
        logic [1:0] rq [12] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
        logic [1:0] lk [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
        logic [1:0] eg [12] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            r2 = rq[c]; l2 = lk[c];
            #4;
            checks++;
            if (g2 !== eg[c] || lk2 !== 1'b0 || v2 !== (eg[c] != 2'b00)) begin
                errors++;
                $display("FAIL n2_mh1 c%0d got g=%b lk=%b v=%b want g=%b lk=0", c, g2, lk2, v2, eg[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lock_cap;
        logic [3:0] eg [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
        logic       el [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            r4 = 4'hF; l4 = 4'b0010;
            #4;
            checks++;
            if (g4 !== eg[c] || lk4 !== el[c]) begin
                errors++;
                $display("FAIL lock_cap c%0d got g=%b lk=%b want g=%b lk=%b", c, g4, lk4, eg[c], el[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_owner_drop;
        logic [3:0] rq [4] = '{4'b0010, 4'b0010, 4'b1100, 4'b1100};
        logic [3:0] eg [4] = '{4'b0010, 4'b0010, 4'b0100, 4'b1000};
        logic       el [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            r4 = rq[c]; l4 = 4'b0010;
            #4;
            checks++;
            if (g4 !== eg[c] || lk4 !== el[c]) begin
                errors++;
                $display("FAIL owner_drop c%0d got g=%b lk=%b want g=%b lk=%b", c, g4, lk4, eg[c], el[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_handover;
        logic [3:0] rq [3] = '{4'b0001, 4'b0110, 4'b0110};
        logic [3:0] lq [3] = '{4'b0001, 4'b0011, 4'b0010};
        logic [3:0] eg [3] = '{4'b0001, 4'b0010, 4'b0010};
        logic       el [3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            r4 = rq[c]; l4 = lq[c];
            #4;
            checks++;
            if (g4 !== eg[c] || lk4 !== el[c]) begin
                errors++;
                $display("FAIL handover c%0d got g=%b lk=%b want g=%b lk=%b", c, g4, lk4, eg[c], el[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_lock;
        logic [3:0] eg [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100};
        logic       el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            r4 = 4'hF; l4 = 4'b0100;
            #4;
            checks++;
            if (g4 !== eg[c] || lk4 !== el[c]) begin
                errors++;
                $display("FAIL rst_mid_pre c%0d got g=%b lk=%b want g=%b lk=%b", c, g4, lk4, eg[c], el[c]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #4;
        checks++;
        if ({g4, v4, id4, lk4} !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_during got g=%b v=%b id=%0d lk=%b want 0", g4, v4, id4, lk4);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        checks++;
        if (g4 !== 4'b0001 || lk4 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after got g=%b lk=%b want 0001 lk=0", g4, lk4);
        end
        @(posedge clk); #1;
        #4;
        checks++;
        if (g4 !== 4'b0010 || lk4 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_next got g=%b lk=%b want 0010 lk=0", g4, lk4);
        end
    endtask

    task automatic test_idle_n3;
        logic [2:0] rq [5] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b111};
        logic [2:0] eg [5] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b001};
        logic [1:0] ei [5] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            r3 = rq[c]; l3 = '0;
            #4;
            checks++;
            if (g3 !== eg[c] || id3 !== ei[c] || v3 !== (eg[c] != 3'b000)) begin
                errors++;
                $display("FAIL idle_n3 c%0d got g=%b id=%0d v=%b want g=%b id=%0d", c, g3, id3, v3, eg[c], ei[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_n2_no_hold();
        test_lock_cap();
        test_owner_drop();
        test_handover();
        test_reset_mid_lock();
        test_idle_n3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
